// File: rtl/idft_stream_ctrl.sv
// Frame sequencer between a valid/ready stream fabric and the 32-word IDFT core.
// Optional WAIT timeout with sticky error flag: define IDFT_CTRL_TIMEOUT_EN.
module idft_stream_ctrl #(
    parameter int FRAME_WORDS    = 32,
    parameter int DW             = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          s_valid_i,
    input  logic [DW-1:0] s_data_i,
    output logic          s_ready_o,
    output logic          m_valid_o,
    output logic [DW-1:0] m_data_o,
    output logic          m_last_o,
    input  logic          m_ready_i,
    output logic          idft_next_o,
    output logic [DW-1:0] idft_x_o,
    input  logic          idft_next_out_i,
    input  logic [DW-1:0] idft_y_i,
    output logic          busy_o,
    output logic          err_o,
    input  logic          err_clr_i
);

    typedef enum logic [2:0] {
        FILL,
        START,
        BURST,
        WAIT,
        CAPTURE,
        DRAIN
    } state_e;

    localparam logic [5:0] LastIdx = 6'(FRAME_WORDS - 1);

    state_e        state_q, state_d;
    logic [5:0]    wcnt_q, wcnt_d;
    logic [5:0]    rcnt_q, rcnt_d;
    logic          nextOutPrev_q;
    logic          nextOutRise;
    logic          timeoutHit;
    logic          ibufWe, obufWe;
    logic          mValid_q, mValid_d;
    logic          mLast_q, mLast_d;
    logic [DW-1:0] mData_q, mData_d;

    logic [DW-1:0] ibuf_q [FRAME_WORDS];
    logic [DW-1:0] obuf_q [FRAME_WORDS];

    assign nextOutRise = idft_next_out_i & ~nextOutPrev_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        ibufWe  = 1'b0;
        obufWe  = 1'b0;
        unique case (state_q)
            FILL: begin
                if (s_valid_i) begin
                    ibufWe = 1'b1;
                    if (wcnt_q == LastIdx) begin
                        wcnt_d  = '0;
                        state_d = START;
                    end else begin
                        wcnt_d = wcnt_q + 6'd1;
                    end
                end
            end
            START: begin
                rcnt_d  = '0;
                state_d = BURST;
            end
            BURST: begin
                if (rcnt_q == LastIdx) begin
                    rcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    rcnt_d = rcnt_q + 6'd1;
                end
            end
            WAIT: begin
                // A rising edge always beats a timeout landing in the same cycle.
                if (nextOutRise) begin
                    wcnt_d  = '0;
                    state_d = CAPTURE;
                end else if (timeoutHit) begin
                    state_d = FILL;
                end
            end
            CAPTURE: begin
                obufWe = 1'b1;
                if (wcnt_q == LastIdx) begin
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    state_d = DRAIN;
                end else begin
                    wcnt_d = wcnt_q + 6'd1;
                end
            end
            DRAIN: begin
                if (mValid_q && m_ready_i) begin
                    if (rcnt_q == LastIdx) begin
                        rcnt_d  = '0;
                        state_d = FILL;
                    end else begin
                        rcnt_d = rcnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Output stage is loaded from the next read pointer so the register always
    // holds the word the consumer is about to see, and stays put while stalled.
    always_comb begin
        mValid_d = (state_d == DRAIN);
        mData_d  = mValid_d ? obuf_q[rcnt_d[4:0]] : '0;
        mLast_d  = mValid_d && (rcnt_d == LastIdx);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= FILL;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            nextOutPrev_q <= 1'b0;
            mValid_q      <= 1'b0;
            mLast_q       <= 1'b0;
            mData_q       <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            nextOutPrev_q <= idft_next_out_i;
            mValid_q      <= mValid_d;
            mLast_q       <= mLast_d;
            mData_q       <= mData_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (ibufWe) begin
            ibuf_q[wcnt_q[4:0]] <= s_data_i;
        end
        if (obufWe) begin
            obuf_q[wcnt_q[4:0]] <= idft_y_i;
        end
    end

`ifdef IDFT_CTRL_TIMEOUT_EN
    localparam int ToW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [ToW-1:0] toCnt_q;
    logic           err_q;

    assign timeoutHit = (toCnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            toCnt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            toCnt_q <= (state_q == WAIT && state_d == WAIT) ? toCnt_q + 1'b1 : '0;
            if (state_q == WAIT && !nextOutRise && timeoutHit) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err_o = err_q;
`else
    logic unusedCfg;

    assign timeoutHit = 1'b0;
    assign err_o      = 1'b0;
    assign unusedCfg  = err_clr_i ^ (TIMEOUT_CYCLES == 0);
`endif

    assign s_ready_o   = (state_q == FILL);
    assign idft_next_o = (state_q == START);
    assign idft_x_o    = (state_q == BURST) ? ibuf_q[rcnt_q[4:0]] : '0;
    assign m_valid_o   = mValid_q;
    assign m_data_o    = mData_q;
    assign m_last_o    = mLast_q;
    assign busy_o      = (state_q != FILL) || (wcnt_q != 6'd0);

endmodule

// File: tb/tb_idft_stream_ctrl.sv
// Directed self-checking bench for idft_stream_ctrl; covers the timeout build
// when IDFT_CTRL_TIMEOUT_EN is defined.
module tb_idft_stream_ctrl;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          idft_next;
    logic [DW-1:0] idft_x;
    logic          next_out;
    logic [DW-1:0] idft_y;
    logic          busy;
    logic          err;
    logic          err_clr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] burstGot [32];
    logic [DW-1:0] drainGot [32];

    always #5 clk = ~clk;

    idft_stream_ctrl #(
        .FRAME_WORDS   (32),
        .DW            (DW),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .s_valid_i       (s_valid),
        .s_data_i        (s_data),
        .s_ready_o       (s_ready),
        .m_valid_o       (m_valid),
        .m_data_o        (m_data),
        .m_last_o        (m_last),
        .m_ready_i       (m_ready),
        .idft_next_o     (idft_next),
        .idft_x_o        (idft_x),
        .idft_next_out_i (next_out),
        .idft_y_i        (idft_y),
        .busy_o          (busy),
        .err_o           (err),
        .err_clr_i       (err_clr)
    );

    // Global watchdog so a wedged DUT still ends the run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        next_out = 1'b0;
        idft_y   = '0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Streams words base+k; with stall the valid alternates 1,0,1,0...
    task automatic stream_frame(input logic [DW-1:0] base, input bit stall,
                                output int accepted, output int cycles);
        int phase;
        accepted = 0;
        cycles   = 0;
        phase    = 0;
        while (accepted < 32 && cycles < 300) begin
            if (stall && (phase % 2 == 1)) begin
                s_valid = 1'b0;
                s_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                s_valid = 1'b1;
                s_data  = base + DW'(accepted);
            end
            if (s_valid && s_ready) accepted++;
            phase++;
            cycles++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    // Called in the START cycle; returns in the first WAIT cycle.
    task automatic observe_burst(output bit startSeen, output int extraNext,
                                 output logic [DW-1:0] afterX);
        startSeen = idft_next;
        extraNext = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            burstGot[k] = idft_x;
            if (idft_next) extraNext++;
        end
        @(posedge clk);
        #1;
        afterX = idft_x;
        if (idft_next) extraNext++;
    endtask

    // Called in WAIT cycle M; drives ybase+k in cycle M+1+k; returns in M+32.
    task automatic feed_core(input logic [DW-1:0] ybase, output int validSeen);
        next_out  = 1'b1;
        idft_y    = 64'h0BAD;
        validSeen = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            if (m_valid) validSeen++;
            idft_y = ybase + DW'(k);
            if (k == 3) next_out = 1'b0;
        end
    endtask

    task automatic drain_frame(input bit stall, output int n, output int lastCnt,
                               output int lastAt, output int unstable);
        int            guard;
        bit            prevStalled;
        logic [DW-1:0] prevData;
        n           = 0;
        lastCnt     = 0;
        lastAt      = -1;
        unstable    = 0;
        guard       = 0;
        prevStalled = 1'b0;
        prevData    = '0;
        while (n < 32 && guard < 400) begin
            m_ready = stall ? guard[0] : 1'b1;
            if (prevStalled && (m_data !== prevData || m_valid !== 1'b1)) unstable++;
            if (m_valid && m_ready) begin
                drainGot[n] = m_data;
                if (m_last) begin
                    lastCnt++;
                    lastAt = n;
                end
                n++;
            end
            prevStalled = m_valid && !m_ready;
            prevData    = m_data;
            @(posedge clk);
            #1;
            guard++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        next_out = 1'b0;
        idft_y   = '0;
        err_clr  = 1'b0;
        #2;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (m_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_m_data: got %h expected 0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last: got %b expected 0", m_last); end
        checks++; if (idft_next !== 1'b0) begin errors++; $display("[TB] FAIL reset_next: got %b expected 0", idft_next); end
        checks++; if (idft_x !== 64'h0) begin errors++; $display("[TB] FAIL reset_x: got %h expected 0", idft_x); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_frame_burst();
        int            acc, cyc, extra;
        bit            startSeen;
        logic [DW-1:0] afterX;
        s_valid = 1'b1;
        s_data  = '0;
        #1;
        stream_frame(64'h0, 1'b0, acc, cyc);
        checks++; if (acc !== 32) begin errors++; $display("[TB] FAIL burst_accepted: got %0d expected 32", acc); end
        checks++; if (cyc !== 32) begin errors++; $display("[TB] FAIL burst_fill_cycles: got %0d expected 32", cyc); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL burst_start_s_ready: got %b expected 0", s_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL burst_start_busy: got %b expected 1", busy); end
        observe_burst(startSeen, extra, afterX);
        checks++; if (startSeen !== 1'b1) begin errors++; $display("[TB] FAIL burst_next_pulse: got %b expected 1", startSeen); end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL burst_next_width: got %0d extra cycles expected 0", extra); end
        for (int k = 0; k < 32; k++) begin
            checks++; if (burstGot[k] !== DW'(k)) begin errors++; $display("[TB] FAIL burst_word%0d: got %h expected %h", k, burstGot[k], DW'(k)); end
        end
        checks++; if (afterX !== 64'h0) begin errors++; $display("[TB] FAIL burst_x_after: got %h expected 0", afterX); end
    endtask

    task automatic test_capture_drain();
        int validSeen, n, lastCnt, lastAt, unstable;
        feed_core(64'h100, validSeen);
        checks++; if (validSeen !== 0) begin errors++; $display("[TB] FAIL cap_early_valid: got %0d beats expected 0", validSeen); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL cap_valid_m32: got %b expected 0", m_valid); end
        @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap_valid_m33: got %b expected 1", m_valid); end
        checks++; if (m_data !== 64'h100) begin errors++; $display("[TB] FAIL cap_first_data: got %h expected 100", m_data); end
        drain_frame(1'b0, n, lastCnt, lastAt, unstable);
        checks++; if (n !== 32) begin errors++; $display("[TB] FAIL drain_beats: got %0d expected 32", n); end
        for (int k = 0; k < 32; k++) begin
            checks++; if (drainGot[k] !== 64'h100 + DW'(k)) begin errors++; $display("[TB] FAIL drain_word%0d: got %h expected %h", k, drainGot[k], 64'h100 + DW'(k)); end
        end
        checks++; if (lastCnt !== 1) begin errors++; $display("[TB] FAIL drain_last_count: got %0d expected 1", lastCnt); end
        checks++; if (lastAt !== 31) begin errors++; $display("[TB] FAIL drain_last_pos: got %0d expected 31", lastAt); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid_after: got %b expected 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_s_ready_after: got %b expected 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drain_busy_after: got %b expected 0", busy); end
    endtask

    // Runs straight after a drain, so it also covers back-to-back frames.
    task automatic test_stalls();
        int            acc, cyc, extra, validSeen, n, lastCnt, lastAt, unstable;
        bit            startSeen;
        logic [DW-1:0] afterX;
        stream_frame(64'h2000, 1'b1, acc, cyc);
        checks++; if (acc !== 32) begin errors++; $display("[TB] FAIL stall_accepted: got %0d expected 32", acc); end
        checks++; if (cyc !== 63) begin errors++; $display("[TB] FAIL stall_fill_cycles: got %0d expected 63", cyc); end
        observe_burst(startSeen, extra, afterX);
        checks++; if (startSeen !== 1'b1) begin errors++; $display("[TB] FAIL stall_next_pulse: got %b expected 1", startSeen); end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL stall_next_width: got %0d expected 0", extra); end
        for (int k = 0; k < 32; k++) begin
            checks++; if (burstGot[k] !== 64'h2000 + DW'(k)) begin errors++; $display("[TB] FAIL stall_burst%0d: got %h expected %h", k, burstGot[k], 64'h2000 + DW'(k)); end
        end
        checks++; if (afterX !== 64'h0) begin errors++; $display("[TB] FAIL stall_burst_len: got %h expected 0", afterX); end
        feed_core(64'h300, validSeen);
        checks++; if (validSeen !== 0) begin errors++; $display("[TB] FAIL stall_early_valid: got %0d expected 0", validSeen); end
        @(posedge clk);
        #1;
        drain_frame(1'b1, n, lastCnt, lastAt, unstable);
        checks++; if (n !== 32) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected 32", n); end
        for (int k = 0; k < 32; k++) begin
            checks++; if (drainGot[k] !== 64'h300 + DW'(k)) begin errors++; $display("[TB] FAIL bp_word%0d: got %h expected %h", k, drainGot[k], 64'h300 + DW'(k)); end
        end
        checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", unstable); end
        checks++; if (lastCnt !== 1 || lastAt !== 31) begin errors++; $display("[TB] FAIL bp_last: got count %0d at %0d expected 1 at 31", lastCnt, lastAt); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_after: got %b expected 0", m_valid); end
    endtask

    task automatic test_reset_mid();
        int            acc, cyc, extra;
        bit            startSeen;
        logic [DW-1:0] afterX;
        stream_frame(64'h4000, 1'b0, acc, cyc);
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
        end
        checks++; if (idft_x !== 64'h400A) begin errors++; $display("[TB] FAIL mid_x_before: got %h expected 400a", idft_x); end
        rst_n = 1'b0;
        #1;
        checks++; if (idft_x !== 64'h0) begin errors++; $display("[TB] FAIL mid_x: got %h expected 0", idft_x); end
        checks++; if (idft_next !== 1'b0) begin errors++; $display("[TB] FAIL mid_next: got %b expected 0", idft_next); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_s_ready: got %b expected 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 64'h0) begin errors++; $display("[TB] FAIL mid_m_out: got %b/%b/%h expected 0/0/0", m_valid, m_last, m_data); end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stream_frame(64'h0, 1'b0, acc, cyc);
        checks++; if (cyc !== 32) begin errors++; $display("[TB] FAIL mid_refill_cycles: got %0d expected 32", cyc); end
        observe_burst(startSeen, extra, afterX);
        checks++; if (startSeen !== 1'b1 || extra !== 0) begin errors++; $display("[TB] FAIL mid_refill_next: got %b/%0d expected 1/0", startSeen, extra); end
        for (int k = 0; k < 32; k++) begin
            checks++; if (burstGot[k] !== DW'(k)) begin errors++; $display("[TB] FAIL mid_refill%0d: got %h expected %h", k, burstGot[k], DW'(k)); end
        end
        do_reset();
    endtask

    task automatic test_spurious_next_out();
        int            acc, cyc, extra, badValid, badReady, validSeen, n, lastCnt, lastAt, unstable;
        bit            startSeen;
        logic [DW-1:0] afterX;
        badValid = 0;
        badReady = 0;
        idft_y   = 64'hBAD0;
        for (int c = 0; c < 40; c++) begin
            next_out = (c >= 2 && c <= 4) || (c == 20);
            m_ready  = 1'b1;
            @(posedge clk);
            #1;
            if (m_valid) badValid++;
            if (!s_ready) badReady++;
        end
        next_out = 1'b0;
        m_ready  = 1'b0;
        checks++; if (badValid !== 0) begin errors++; $display("[TB] FAIL spur_fill_beats: got %0d expected 0", badValid); end
        checks++; if (badReady !== 0) begin errors++; $display("[TB] FAIL spur_fill_ready: got %0d low cycles expected 0", badReady); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL spur_fill_busy: got %b expected 0", busy); end
        // next_out held high from BURST into WAIT is a level, not an edge.
        stream_frame(64'h7000, 1'b0, acc, cyc);
        next_out = 1'b1;
        observe_burst(startSeen, extra, afterX);
        badValid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (m_valid) badValid++;
        end
        checks++; if (badValid !== 0) begin errors++; $display("[TB] FAIL spur_level_beats: got %0d expected 0", badValid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL spur_level_waiting: got %b expected 0", s_ready); end
        next_out = 1'b0;
        @(posedge clk);
        #1;
        feed_core(64'h700, validSeen);
        @(posedge clk);
        #1;
        drain_frame(1'b0, n, lastCnt, lastAt, unstable);
        checks++; if (n !== 32 || drainGot[0] !== 64'h700 || drainGot[31] !== 64'h71F) begin errors++; $display("[TB] FAIL spur_recover: got %0d beats %h..%h expected 32 beats 700..71f", n, drainGot[0], drainGot[31]); end
    endtask

    task automatic test_timeout();
        int            acc, cyc, extra, bad;
        bit            startSeen;
        logic [DW-1:0] afterX;
`ifndef IDFT_CTRL_TIMEOUT_EN
        int            validSeen, n, lastCnt, lastAt, unstable;
`endif
        do_reset();
        stream_frame(64'h800, 1'b0, acc, cyc);
        observe_burst(startSeen, extra, afterX);
        bad = 0;
`ifdef IDFT_CTRL_TIMEOUT_EN
        for (int w = 1; w < 4096; w++) begin
            if (err || s_ready) bad++;
            @(posedge clk);
            #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL to_early: got %0d bad cycles expected 0", bad); end
        checks++; if (err !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL to_last_wait: got err %b ready %b expected 0/0", err, s_ready); end
        @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL to_err_set: got %b expected 1", err); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_s_ready: got %b expected 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_no_output: got %b expected 0", m_valid); end
        @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL to_err_sticky: got %b expected 1", err); end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_clear: got %b expected 0", err); end
`else
        err_clr = 1'b1;
        for (int w = 0; w < 4200; w++) begin
            if (err || s_ready || m_valid) bad++;
            @(posedge clk);
            #1;
        end
        err_clr = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL nto_wait: got %0d bad cycles expected 0", bad); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nto_busy: got %b expected 1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL nto_err: got %b expected 0", err); end
        feed_core(64'h900, validSeen);
        @(posedge clk);
        #1;
        drain_frame(1'b0, n, lastCnt, lastAt, unstable);
        checks++; if (n !== 32 || drainGot[0] !== 64'h900 || drainGot[31] !== 64'h91F) begin errors++; $display("[TB] FAIL nto_recover: got %0d beats %h..%h expected 32 beats 900..91f", n, drainGot[0], drainGot[31]); end
        checks++; if (lastAt !== 31) begin errors++; $display("[TB] FAIL nto_last: got %0d expected 31", lastAt); end
`endif
    endtask

    initial begin
        rst_n    = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        next_out = 1'b0;
        idft_y   = '0;
        err_clr  = 1'b0;
        test_reset();
        test_frame_burst();
        test_capture_drain();
        test_stalls();
        test_reset_mid();
        test_spurious_next_out();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
